pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 26: PC/address width.
REQ-002 SHALL have parameter OFF_W, default 16: width of desvio (branch/JAL target), OFF_W <= ADDR_W.
REQ-003 SHALL have parameter RAS_DEPTH, default 8: return-address-stack entries, power of two >= 2.
REQ-004 SHALL have parameter RESET_VEC, default 0: PC value after reset.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  0 = stall; all state frozen
- addOp  in  2  00 hold, 01 increment, 10 opcode-decoded, 11 jump
- opcode  in  6  instruction opcode
- menor, maior, igual  in  1 each  ALU flags
- desvio  in  OFF_W  branch/JAL target
- salto  in  ADDR_W  jump target
- jr_target  in  ADDR_W  register-file value for JR
- ras_en  in  1  1 = JAL pushes and JR pops the RAS
- clr_flags  in  1  clears sticky flags
- pc  out  ADDR_W  registered current PC
- pc_next  out  ADDR_W  combinational value loaded at next enabled edge
- redirect  out  1  registered, 1 for the cycle after a non-sequential PC load
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow, ras_underflow  out  1 each  sticky error flags

Function
REQ-006 SHALL decode opcodes BEQ=010111, BNE=011000, BLT=011001, BLET=011010, BGT=011011, BGET=011100, JAL=011110, JR=011111.
REQ-007 SHALL compute pc_next: addOp=00 -> pc; 01 -> pc+1; 11 -> salto; 10 -> per REQ-008..REQ-011.
REQ-008 For branches under addOp=10, SHALL fall through (pc+1) when the condition holds, else load zero-extended desvio. Conditions: BEQ igual; BNE !igual; BLT menor; BLET menor|igual; BGT maior; BGET maior|igual.
REQ-009 For JAL under addOp=10, SHALL load zero-extended desvio; with ras_en=1, SHALL push pc+1.
REQ-010 For JR under addOp=10, SHALL load the RAS top and pop when ras_en=1 and ras_count>0; otherwise SHALL load jr_target.
REQ-011 For any other opcode under addOp=10, SHALL produce pc+1.
REQ-012 pc+1 SHALL wrap modulo 2^ADDR_W; pc = all-ones increments to 0.
REQ-013 On each rising clock edge with enable=1, pc SHALL load pc_next, with one-cycle latency from inputs to pc.
REQ-014 On each enabled edge, redirect SHALL be 1 iff pc_next != pc+1 and addOp != 00; a taken branch whose target equals pc+1 does not redirect.
REQ-015 enable=0 SHALL hold pc, the RAS, ras_count and the flags, and SHALL force redirect to 0 at that edge.
REQ-016 RAS push on a full stack SHALL overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH, and set ras_overflow.
REQ-017 JR with ras_en=1 and ras_count=0 SHALL use jr_target and set ras_underflow.
REQ-018 The RAS SHALL perform at most one push or one pop per cycle; JAL and JR are mutually exclusive by opcode.
REQ-019 clr_flags=1 at an enabled edge SHALL clear both flags; a new error in the same cycle wins (flag ends at 1).
REQ-020 pc_next SHALL be purely combinational from pc, the RAS top and inputs, with no latches.

Reset
REQ-021 reset=1 SHALL immediately (asynchronously) set pc=RESET_VEC, redirect=0, ras_count=0, ras_overflow=0, ras_underflow=0. RAS storage contents are don't-care.
REQ-022 Reset asserted mid-operation SHALL discard any pending push or pop. The first enabled edge after deassertion SHALL load pc_next computed from RESET_VEC.

Verification
REQ-023 Reset then addOp=01 for 3 cycles -> pc 0,1,2,3; redirect stays 0.
REQ-024 pc=10, addOp=10, BEQ, igual=0, desvio=40 -> pc=40, redirect=1 for one cycle. Repeat with igual=1 -> pc=11, redirect=0.
REQ-025 pc=5, JAL desvio=100, ras_en=1 -> pc=100, ras_count=1. Then JR with jr_target=7 -> pc=6, ras_count=0. Another JR -> pc=7, ras_underflow=1.
REQ-026 With RAS_DEPTH=8, nine JALs -> ras_count=8, ras_overflow=1. Eight JRs return the last 8 pushed addresses newest-first.
REQ-027 ADDR_W=26, pc=26'h3FFFFFF, addOp=01 -> pc=0. Then enable=0 with addOp=11, salto=50 for 2 cycles -> pc holds 0, redirect=0.
REQ-028 Assert reset asynchronously between edges while a JAL is pending -> pc=RESET_VEC at once, ras_count=0, no push after release.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// PC sequencer control/status bundle: instruction-decode inputs in, PC and RAS status out.
// Purely wiring; no storage, no latency of its own.
// No backpressure; the enable input is the only stall mechanism.
interface pc_sequencer_if #(
   parameter int ADDR_W    = 26,
   parameter int OFF_W     = 16,
   parameter int RAS_DEPTH = 8
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              enable;
   logic [1:0]        addOp;
   logic [5:0]        opcode;
   logic              menor;
   logic              maior;
   logic              igual;
   logic [OFF_W-1:0]  desvio;
   logic [ADDR_W-1:0] salto;
   logic [ADDR_W-1:0] jr_target;
   logic              ras_en;
   logic              clr_flags;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic              redirect;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_overflow;
   logic              ras_underflow;

   modport master (
      output enable, addOp, opcode, menor, maior, igual, desvio, salto, jr_target, ras_en, clr_flags,
      input  pc, pc_next, redirect, ras_count, ras_overflow, ras_underflow
   );

   modport slave (
      input  enable, addOp, opcode, menor, maior, igual, desvio, salto, jr_target, ras_en, clr_flags,
      output pc, pc_next, redirect, ras_count, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with branch/jump decode and a circular return-address stack.
// pc_next is combinational; pc, redirect and RAS state update one cycle later.
// enable=0 stalls everything (pc, RAS, flags held; redirect forced low).
module pc_sequencer #(
   parameter int                ADDR_W    = 26,
   parameter int                OFF_W     = 16,
   parameter int                RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input logic            clock,
   input logic            reset,
   pc_sequencer_if.slave  bus
);
   localparam int SP_W  = $clog2(RAS_DEPTH);
   localparam int CNT_W = SP_W + 1;

   localparam logic [5:0] OP_BEQ  = 6'b010111;
   localparam logic [5:0] OP_BNE  = 6'b011000;
   localparam logic [5:0] OP_BLT  = 6'b011001;
   localparam logic [5:0] OP_BLET = 6'b011010;
   localparam logic [5:0] OP_BGT  = 6'b011011;
   localparam logic [5:0] OP_BGET = 6'b011100;
   localparam logic [5:0] OP_JAL  = 6'b011110;
   localparam logic [5:0] OP_JR   = 6'b011111;

   logic [ADDR_W-1:0] pc_q;
   logic              redirect_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;
   logic              unf_q;
   // sp points at the slot the next push writes; the top is sp-1.
   logic [SP_W-1:0]   sp_q;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] tgt;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] nxt;
   logic              push;
   logic              pop;
   logic              under;
   logic              full;

   assign pc_inc  = pc_q + ADDR_W'(1);
   assign tgt     = ADDR_W'(bus.desvio);
   assign ras_top = ras_mem[sp_q - SP_W'(1)];
   assign full    = (cnt_q == CNT_W'(RAS_DEPTH));

   // Next-PC select and RAS push/pop request decode.
   always_comb begin
      nxt   = pc_inc;
      push  = 1'b0;
      pop   = 1'b0;
      under = 1'b0;
      case (bus.addOp)
         2'b00: nxt = pc_q;
         2'b01: nxt = pc_inc;
         2'b11: nxt = bus.salto;
         default: begin
            // Branches fall through when their condition holds, else take desvio.
            case (bus.opcode)
               OP_BEQ:  nxt = bus.igual                ? pc_inc : tgt;
               OP_BNE:  nxt = !bus.igual               ? pc_inc : tgt;
               OP_BLT:  nxt = bus.menor                ? pc_inc : tgt;
               OP_BLET: nxt = (bus.menor || bus.igual) ? pc_inc : tgt;
               OP_BGT:  nxt = bus.maior                ? pc_inc : tgt;
               OP_BGET: nxt = (bus.maior || bus.igual) ? pc_inc : tgt;
               OP_JAL: begin
                  nxt  = tgt;
                  push = bus.ras_en;
               end
               OP_JR: begin
                  if (bus.ras_en && (cnt_q != '0)) begin
                     nxt = ras_top;
                     pop = 1'b1;
                  end else begin
                     nxt   = bus.jr_target;
                     under = bus.ras_en;
                  end
               end
               default: nxt = pc_inc;
            endcase
         end
      endcase
   end

   // PC, redirect, RAS pointer/count and sticky flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_VEC;
         redirect_q <= 1'b0;
         cnt_q      <= '0;
         sp_q       <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else if (bus.enable) begin
         pc_q       <= nxt;
         redirect_q <= (bus.addOp != 2'b00) && (nxt != pc_inc);
         if (push) begin
            sp_q  <= sp_q + SP_W'(1);
            cnt_q <= full ? cnt_q : cnt_q + CNT_W'(1);
         end else if (pop) begin
            sp_q  <= sp_q - SP_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
         end
         ovf_q <= (ovf_q && !bus.clr_flags) || (push && full);
         unf_q <= (unf_q && !bus.clr_flags) || under;
      end else begin
         redirect_q <= 1'b0;
      end
   end

   // RAS storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clock) begin
      if (bus.enable && push && !reset) begin
         ras_mem[sp_q] <= pc_inc;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_next       = nxt;
   assign bus.redirect      = redirect_q;
   assign bus.ras_count     = cnt_q;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic vs. a queue-based model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Model tracks the PC as an integer and the RAS as a bounded queue.
module tb_pc_sequencer;
   localparam int    ADDR_W = 26;
   localparam int    OFF_W  = 16;
   localparam int    DEPTH  = 8;
   localparam longint MOD   = 64'd1 << ADDR_W;

   localparam logic [5:0] BEQ = 6'b010111, BNE = 6'b011000, BLT = 6'b011001, BLET = 6'b011010;
   localparam logic [5:0] BGT = 6'b011011, BGET = 6'b011100, JAL = 6'b011110, JR = 6'b011111;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   longint m_pc;
   longint m_ras[$];
   bit     m_redir, m_ovf, m_unf;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)) bus ();

   pc_sequencer #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH), .RESET_VEC('0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected next PC and RAS action from the architectural rules.
   task automatic model_next(output longint nxt, output bit push, output bit pop, output bit under);
      longint inc;
      bit     cond;
      inc   = (m_pc + 1) % MOD;
      push  = 0;
      pop   = 0;
      under = 0;
      nxt   = inc;
      if (bus.addOp == 2'd0) nxt = m_pc;
      else if (bus.addOp == 2'd3) nxt = longint'(bus.salto);
      else if (bus.addOp == 2'd2) begin
         if (bus.opcode == JAL) begin
            nxt  = longint'(bus.desvio);
            push = bus.ras_en;
         end else if (bus.opcode == JR) begin
            if (bus.ras_en && m_ras.size() > 0) begin
               nxt = m_ras[m_ras.size() - 1];
               pop = 1;
            end else begin
               nxt   = longint'(bus.jr_target);
               under = bus.ras_en;
            end
         end else if (bus.opcode inside {BEQ, BNE, BLT, BLET, BGT, BGET}) begin
            case (bus.opcode)
               BEQ:     cond = bus.igual;
               BNE:     cond = !bus.igual;
               BLT:     cond = bus.menor;
               BLET:    cond = bus.menor | bus.igual;
               BGT:     cond = bus.maior;
               default: cond = bus.maior | bus.igual;
            endcase
            nxt = cond ? inc : longint'(bus.desvio);
         end
      end
   endtask

   // One clock: advance the model at the rising edge, return at the falling edge.
   task automatic cycle();
      longint nxt;
      bit push, pop, under, ovf_new;
      @(posedge clock);
      if (reset) begin
         m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_redir = 0;
      end else if (!bus.enable) begin
         m_redir = 0;
      end else begin
         model_next(nxt, push, pop, under);
         m_redir = (bus.addOp != 2'd0) && (nxt != (m_pc + 1) % MOD);
         ovf_new = 0;
         if (push) begin
            m_ras.push_back((m_pc + 1) % MOD);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               ovf_new = 1;
            end
         end
         if (pop) void'(m_ras.pop_back());
         m_ovf = (m_ovf && !bus.clr_flags) || ovf_new;
         m_unf = (m_unf && !bus.clr_flags) || under;
         m_pc  = nxt;
      end
      @(negedge clock);
   endtask

   task automatic idle();
      bus.enable = 1; bus.addOp = 2'd0; bus.opcode = 6'd0;
      bus.menor = 0; bus.maior = 0; bus.igual = 0;
      bus.desvio = '0; bus.salto = '0; bus.jr_target = '0;
      bus.ras_en = 0; bus.clr_flags = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_redir = 0;
      #3;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic jump_to(input longint a);
      idle(); bus.addOp = 2'd3; bus.salto = ADDR_W'(a); cycle(); idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #2;
      checks++;
      if (bus.pc !== '0 || bus.redirect !== 1'b0 || bus.ras_count !== '0 ||
          bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state pc=%0d redir=%0b cnt=%0d ovf=%0b unf=%0b required all 0",
                  bus.pc, bus.redirect, bus.ras_count, bus.ras_overflow, bus.ras_underflow);
      end
      @(negedge clock);
      reset = 1'b0;
      m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_redir = 0;
   endtask

   task automatic test_increment();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         bus.addOp = 2'd1;
         cycle();
         checks++;
         if (bus.pc !== ADDR_W'(i) || bus.redirect !== 1'b0) begin
            errors++;
            $display("FAIL increment step%0d pc=%0d redir=%0b required pc=%0d redir=0", i, bus.pc, bus.redirect, i);
         end
      end
   endtask

   task automatic test_branch();
      jump_to(10);
      bus.addOp = 2'd2; bus.opcode = BEQ; bus.igual = 0; bus.desvio = 16'd40;
      cycle();
      checks++;
      if (bus.pc !== 26'd40 || bus.redirect !== 1'b1) begin
         errors++;
         $display("FAIL beq_taken pc=%0d redir=%0b required pc=40 redir=1", bus.pc, bus.redirect);
      end
      idle(); cycle();
      checks++;
      if (bus.redirect !== 1'b0) begin
         errors++;
         $display("FAIL beq_redirect_one_cycle redir=%0b required 0", bus.redirect);
      end
      jump_to(10);
      bus.addOp = 2'd2; bus.opcode = BEQ; bus.igual = 1; bus.desvio = 16'd40;
      cycle();
      checks++;
      if (bus.pc !== 26'd11 || bus.redirect !== 1'b0) begin
         errors++;
         $display("FAIL beq_fallthrough pc=%0d redir=%0b required pc=11 redir=0", bus.pc, bus.redirect);
      end
      jump_to(10);
      bus.addOp = 2'd2; bus.opcode = BLT; bus.menor = 0; bus.desvio = 16'd11;
      cycle();
      checks++;
      if (bus.pc !== 26'd11 || bus.redirect !== 1'b0) begin
         errors++;
         $display("FAIL branch_to_pc_plus1 pc=%0d redir=%0b required pc=11 redir=0", bus.pc, bus.redirect);
      end
   endtask

   task automatic test_ras_basic();
      do_reset();
      jump_to(5);
      bus.addOp = 2'd2; bus.opcode = JAL; bus.desvio = 16'd100; bus.ras_en = 1;
      cycle();
      checks++;
      if (bus.pc !== 26'd100 || bus.ras_count !== 4'd1) begin
         errors++;
         $display("FAIL jal pc=%0d cnt=%0d required pc=100 cnt=1", bus.pc, bus.ras_count);
      end
      bus.opcode = JR; bus.jr_target = 26'd7;
      cycle();
      checks++;
      if (bus.pc !== 26'd6 || bus.ras_count !== 4'd0) begin
         errors++;
         $display("FAIL jr_pop pc=%0d cnt=%0d required pc=6 cnt=0", bus.pc, bus.ras_count);
      end
      cycle();
      checks++;
      if (bus.pc !== 26'd7 || bus.ras_underflow !== 1'b1 || bus.ras_count !== 4'd0) begin
         errors++;
         $display("FAIL jr_underflow pc=%0d unf=%0b cnt=%0d required pc=7 unf=1 cnt=0",
                  bus.pc, bus.ras_underflow, bus.ras_count);
      end
      // Clear in the same cycle as a new underflow: the new error wins.
      bus.clr_flags = 1;
      cycle();
      checks++;
      if (bus.ras_underflow !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_new_error unf=%0b required 1", bus.ras_underflow);
      end
      idle(); bus.clr_flags = 1;
      cycle();
      checks++;
      if (bus.ras_underflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_flags unf=%0b required 0", bus.ras_underflow);
      end
      idle();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         bus.addOp = 2'd2; bus.opcode = JAL; bus.ras_en = 1; bus.desvio = OFF_W'(100 + i);
         cycle();
      end
      checks++;
      if (bus.ras_count !== 4'd8 || bus.ras_overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow cnt=%0d ovf=%0b required cnt=8 ovf=1", bus.ras_count, bus.ras_overflow);
      end
      for (int k = 0; k < 8; k++) begin
         bus.opcode = JR; bus.jr_target = 26'd3;
         cycle();
         checks++;
         if (bus.pc !== ADDR_W'(108 - k)) begin
            errors++;
            $display("FAIL ras_pop_order k=%0d pc=%0d required %0d", k, bus.pc, 108 - k);
         end
      end
      idle();
   endtask

   task automatic test_wrap_stall();
      jump_to(MOD - 1);
      bus.addOp = 2'd1;
      cycle();
      checks++;
      if (bus.pc !== '0 || bus.redirect !== 1'b0) begin
         errors++;
         $display("FAIL pc_wrap pc=%0d redir=%0b required pc=0 redir=0", bus.pc, bus.redirect);
      end
      bus.enable = 0; bus.addOp = 2'd3; bus.salto = 26'd50;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (bus.pc !== '0 || bus.redirect !== 1'b0) begin
            errors++;
            $display("FAIL stall cyc%0d pc=%0d redir=%0b required pc=0 redir=0", i, bus.pc, bus.redirect);
         end
      end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      jump_to(20);
      bus.addOp = 2'd2; bus.opcode = JAL; bus.ras_en = 1; bus.desvio = 16'd300;
      cycle();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.pc !== '0 || bus.ras_count !== '0 || bus.redirect !== 1'b0) begin
         errors++;
         $display("FAIL async_reset pc=%0d cnt=%0d redir=%0b required 0/0/0", bus.pc, bus.ras_count, bus.redirect);
      end
      idle(); bus.addOp = 2'd1;
      #1 reset = 1'b0;
      m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_redir = 0;
      cycle();
      checks++;
      if (bus.pc !== 26'd1 || bus.ras_count !== '0) begin
         errors++;
         $display("FAIL after_reset pc=%0d cnt=%0d required pc=1 cnt=0", bus.pc, bus.ras_count);
      end
      idle();
   endtask

   task automatic test_random();
      logic [5:0] ops [10] = '{BEQ, BNE, BLT, BLET, BGT, BGET, JAL, JR, 6'd0, 6'd63};
      longint nxt;
      bit push, pop, under;
      int bad;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.addOp     = 2'($urandom_range(0, 9) < 6 ? 2 : $urandom_range(0, 3));
         bus.opcode    = ops[$urandom_range(0, 9)];
         bus.menor     = 1'($urandom);
         bus.maior     = 1'($urandom);
         bus.igual     = 1'($urandom);
         bus.desvio    = OFF_W'($urandom_range(0, 40));
         bus.salto     = ADDR_W'($urandom);
         bus.jr_target = ADDR_W'($urandom);
         bus.ras_en    = ($urandom_range(0, 4) != 0);
         bus.clr_flags = ($urandom_range(0, 9) == 0);
         #1;
         model_next(nxt, push, pop, under);
         checks++;
         if (longint'(bus.pc_next) !== nxt) begin
            errors++;
            if (bad++ < 10) $display("FAIL rand_pc_next i=%0d got=%0d required=%0d", i, bus.pc_next, nxt);
         end
         cycle();
         checks++;
         if (longint'(bus.pc) !== m_pc || bus.redirect !== m_redir ||
             int'(bus.ras_count) !== m_ras.size() || bus.ras_overflow !== m_ovf || bus.ras_underflow !== m_unf) begin
            errors++;
            if (bad++ < 10)
               $display("FAIL rand_state i=%0d pc=%0d/%0d redir=%0b/%0b cnt=%0d/%0d ovf=%0b/%0b unf=%0b/%0b (got/required)",
                        i, bus.pc, m_pc, bus.redirect, m_redir, bus.ras_count, m_ras.size(),
                        bus.ras_overflow, m_ovf, bus.ras_underflow, m_unf);
         end
      end
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      @(negedge clock);
      test_reset();
      test_increment();
      test_branch();
      test_ras_basic();
      test_overflow();
      test_wrap_stall();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
